h264dc_quantise: RTL and testbench

- Chroma DC quantiser; sits directly downstream of h264dc_transform.
- Consumes the serial 2x2 Hadamard outputs (4 coefficients per block) and applies H.264 DC quantisation for the block's QP.
- Emits quantised levels to the coefficient buffer / CAVLC path with ready/valid backpressure.
- Also produces a per-block nonzero flag for CBP chroma decisions.

---
 rtl/h264dc_quantise_if.sv | 28 ++
 rtl/h264dc_quantise.sv | 217 +++++++++++++++++++++
 tb/tb_h264dc_quantise.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/h264dc_quantise_if.sv
// Bus bundle for the chroma DC quantiser: upstream coefficient stream in,
// quantised level stream out, plus block-level QP/INTRA sideband.
interface h264dc_quantise_if;
  // Handshake: a beat moves on a rising edge only when valid and ready are
  // both high. Upstream (VALIDI/READYO) and downstream (VALID/READYI) behave
  // this way independently, and a source holds its data while it waits.
  logic               ENABLE;
  logic [5:0]         QP;
  logic               INTRA;
  logic               VALIDI;
  logic signed [15:0] YYIN;
  logic               READYO;
  logic               READYI;
  logic               VALID;
  logic signed [15:0] ZOUT;
  logic               LAST;
  logic               NZ;

  modport master (
    output ENABLE, QP, INTRA, VALIDI, YYIN, READYI,
    input  READYO, VALID, ZOUT, LAST, NZ
  );

  modport slave (
    input  ENABLE, QP, INTRA, VALIDI, YYIN, READYI,
    output READYO, VALID, ZOUT, LAST, NZ
  );
endinterface

// File: rtl/h264dc_quantise.sv
// Chroma DC quantiser: three-stage pipeline turning 2x2 Hadamard outputs into
// H.264 quantised levels, with a per-block nonzero flag for CBP decisions.
module h264dc_quantise #(
  parameter int QPMAX = 51,
  parameter int PIPE  = 3
) (
  input logic              CLK,
  input logic              RESET,
  h264dc_quantise_if.slave dc
);

  localparam logic [5:0]  QPMAX_L = 6'(QPMAX);
  // Only the three-stage build exists; any other depth never accepts input.
  localparam logic        PIPE_OK = (PIPE == 3);
  // Bit pattern 0101...01: shifting it right yields floor(2^n/3) for n <= 30.
  localparam logic [29:0] THIRDS  = 30'h1555_5555;

  // Block sequencing state
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  qpl_q, qpl_d;
  logic        intral_q, intral_d;

  // Stage 1: magnitude, sign, multiplier and shift
  logic        v1_q, v1_d;
  logic        sign1_q, sign1_d;
  logic [14:0] a1_q, a1_d;
  logic [13:0] m1_q, m1_d;
  logic [4:0]  sh1_q, sh1_d;
  logic        intra1_q, intra1_d;
  logic        last1_q, last1_d;

  // Stage 2: rounded product
  logic        v2_q, v2_d;
  logic        sign2_q, sign2_d;
  logic [29:0] s2_q, s2_d;
  logic [4:0]  sh2_q, sh2_d;
  logic        last2_q, last2_d;

  // Stage 3: output register and nonzero accumulator
  logic        valid_q, valid_d;
  logic [15:0] zout_q, zout_d;
  logic        last_q, last_d;
  logic        nz_q, nz_d;
  logic        nzacc_q, nzacc_d;

  // Combinational helpers
  logic        adv;
  logic        ready;
  logic        accept;
  logic        first;
  logic [5:0]  qp_clamp;
  logic [5:0]  qp_eff;
  logic        intra_eff;
  logic [3:0]  qdiv;
  logic [2:0]  qmod;
  logic [13:0] mf;
  logic [14:0] a_mag;
  logic [4:0]  sh;
  logic [28:0] p;
  logic [29:0] f2;
  logic [15:0] z;
  logic        z_nz;

  always_comb begin
    adv       = !valid_q || dc.READYI;
    ready     = dc.ENABLE && adv && RESET && PIPE_OK;
    accept    = dc.VALIDI && ready;
    first     = (idx_q == 2'd0);
    qp_clamp  = (dc.QP > QPMAX_L) ? QPMAX_L : dc.QP;
    qp_eff    = first ? qp_clamp : qpl_q;
    intra_eff = first ? dc.INTRA : intral_q;
    qdiv      = 4'(qp_eff / 6'd6);
    qmod      = 3'(qp_eff % 6'd6);
    sh        = 5'd16 + {1'b0, qdiv};

    mf = 14'd13107;
    case (qmod)
      3'd0:    mf = 14'd13107;
      3'd1:    mf = 14'd11916;
      3'd2:    mf = 14'd10082;
      3'd3:    mf = 14'd9362;
      3'd4:    mf = 14'd8192;
      3'd5:    mf = 14'd7282;
      default: mf = 14'd13107;
    endcase

    // -32768 has no positive twin in 16 bits, so it saturates to 32767.
    if (dc.YYIN == 16'sh8000)
      a_mag = 15'h7fff;
    else if (dc.YYIN[15])
      a_mag = 15'(16'(~dc.YYIN) + 16'd1);
    else
      a_mag = dc.YYIN[14:0];

    p    = 29'(a1_q) * 29'(m1_q);
    f2   = intra1_q ? (THIRDS >> (5'd30 - sh1_q)) : (THIRDS >> (5'd31 - sh1_q));
    z    = 16'(s2_q >> sh2_q);
    z_nz = (z != 16'd0);
  end

  always_comb begin
    idx_d    = idx_q;
    qpl_d    = qpl_q;
    intral_d = intral_q;
    v1_d     = v1_q;
    sign1_d  = sign1_q;
    a1_d     = a1_q;
    m1_d     = m1_q;
    sh1_d    = sh1_q;
    intra1_d = intra1_q;
    last1_d  = last1_q;
    v2_d     = v2_q;
    sign2_d  = sign2_q;
    s2_d     = s2_q;
    sh2_d    = sh2_q;
    last2_d  = last2_q;
    valid_d  = valid_q;
    zout_d   = zout_q;
    last_d   = last_q;
    nz_d     = nz_q;
    nzacc_d  = nzacc_q;

    if (accept) begin
      idx_d = idx_q + 2'd1;
      if (first) begin
        qpl_d    = qp_clamp;
        intral_d = dc.INTRA;
      end
    end

    if (adv) begin
      v1_d = accept;
      if (accept) begin
        sign1_d  = dc.YYIN[15];
        a1_d     = a_mag;
        m1_d     = mf;
        sh1_d    = sh;
        intra1_d = intra_eff;
        last1_d  = (idx_q == 2'd3);
      end

      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        s2_d    = {1'b0, p} + f2;
        sh2_d   = sh1_q;
        last2_d = last1_q;
      end

      valid_d = v2_q;
      if (v2_q) begin
        zout_d  = sign2_q ? (16'd0 - z) : z;
        last_d  = last2_q;
        nz_d    = nzacc_q || z_nz;
        // The next load can only happen once this LAST level has been taken,
        // so clearing here is the same as clearing on the downstream accept.
        nzacc_d = last2_q ? 1'b0 : (nzacc_q || z_nz);
      end else begin
        last_d = 1'b0;
        nz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx_q    <= 2'd0;
      qpl_q    <= 6'd0;
      intral_q <= 1'b0;
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      a1_q     <= 15'd0;
      m1_q     <= 14'd0;
      sh1_q    <= 5'd0;
      intra1_q <= 1'b0;
      last1_q  <= 1'b0;
      v2_q     <= 1'b0;
      sign2_q  <= 1'b0;
      s2_q     <= 30'd0;
      sh2_q    <= 5'd0;
      last2_q  <= 1'b0;
      valid_q  <= 1'b0;
      zout_q   <= 16'd0;
      last_q   <= 1'b0;
      nz_q     <= 1'b0;
      nzacc_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      qpl_q    <= qpl_d;
      intral_q <= intral_d;
      v1_q     <= v1_d;
      sign1_q  <= sign1_d;
      a1_q     <= a1_d;
      m1_q     <= m1_d;
      sh1_q    <= sh1_d;
      intra1_q <= intra1_d;
      last1_q  <= last1_d;
      v2_q     <= v2_d;
      sign2_q  <= sign2_d;
      s2_q     <= s2_d;
      sh2_q    <= sh2_d;
      last2_q  <= last2_d;
      valid_q  <= valid_d;
      zout_q   <= zout_d;
      last_q   <= last_d;
      nz_q     <= nz_d;
      nzacc_q  <= nzacc_d;
    end
  end

  assign dc.READYO = ready;
  assign dc.VALID  = valid_q;
  assign dc.ZOUT   = zout_q;
  assign dc.LAST   = last_q;
  assign dc.NZ     = nz_q;

endmodule

// File: tb/tb_h264dc_quantise.sv
// Directed bench for h264dc_quantise: each task drives one scenario and checks
// the captured levels against hand-computed values.
module tb_h264dc_quantise;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  h264dc_quantise_if dc();

  h264dc_quantise #(.QPMAX(51), .PIPE(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .dc    (dc)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Levels taken by downstream, with the cycle they were seen
  logic signed [15:0] got_z[$];
  logic               got_last[$];
  logic               got_nz[$];
  int                 got_cyc[$];

  always @(negedge CLK) begin
    if (RESET && dc.VALID && dc.READYI) begin
      got_z.push_back(dc.ZOUT);
      got_last.push_back(dc.LAST);
      got_nz.push_back(dc.NZ);
      got_cyc.push_back(cyc);
    end
  end

  task automatic clear_got();
    got_z.delete();
    got_last.delete();
    got_nz.delete();
    got_cyc.delete();
  endtask

  // Present one coefficient and wait for it to be accepted; leaves VALIDI high.
  task automatic send(input logic signed [15:0] v, input logic [5:0] qp,
                      input logic intra, output int acc_cyc);
    bit done = 1'b0;
    dc.VALIDI = 1'b1;
    dc.YYIN   = v;
    dc.QP     = qp;
    dc.INTRA  = intra;
    acc_cyc   = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (dc.READYO) begin
        acc_cyc = cyc;
        done    = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout value %0d never accepted", v);
    end
  endtask

  task automatic send_block(input logic signed [15:0] v0, v1, v2, v3,
                            input logic [5:0] qp, input logic intra, output int acc0);
    int a;
    send(v0, qp, intra, acc0);
    send(v1, qp, intra, a);
    send(v2, qp, intra, a);
    send(v3, qp, intra, a);
    dc.VALIDI = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (got_z.size() < n && k < 60) begin
      @(posedge CLK);
      #1;
      k++;
    end
    if (got_z.size() < n) begin
      tests++;
      fails++;
      $display("FAIL wait_out got %0d levels want %0d", got_z.size(), n);
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET     = 1'b0;
    dc.ENABLE = 1'b1;
    dc.READYI = 1'b1;
    dc.VALIDI = 1'b1;
    dc.YYIN   = 16'sd100;
    dc.QP     = 6'd28;
    dc.INTRA  = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests++; if (dc.VALID !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dc.VALID); end
    tests++; if (dc.ZOUT !== 16'sd0) begin fails++; $display("FAIL reset_zout got %0d want 0", dc.ZOUT); end
    tests++; if (dc.LAST !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", dc.LAST); end
    tests++; if (dc.NZ !== 1'b0) begin fails++; $display("FAIL reset_nz got %b want 0", dc.NZ); end
    tests++; if (dc.READYO !== 1'b0) begin fails++; $display("FAIL reset_readyo got %b want 0", dc.READYO); end
    dc.VALIDI = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      tests++; if (dc.VALID !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got %b want 0", dc.VALID); end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_intra_basic();
    logic signed [15:0] ez[4] = '{16'sd1, -16'sd1, 16'sd8, 16'sd0};
    int acc;
    clear_got();
    send_block(16'sd100, -16'sd100, 16'sd1000, 16'sd0, 6'd28, 1'b1, acc);
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL intra_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== ez[i]) begin fails++; $display("FAIL intra_z%0d got %0d want %0d", i, got_z[i], ez[i]); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL intra_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
    tests++; if (got_nz[3] !== 1'b1) begin fails++; $display("FAIL intra_nz got %b want 1", got_nz[3]); end
    tests++; if (got_cyc[0] - acc !== 3) begin fails++; $display("FAIL intra_latency got %0d want 3", got_cyc[0] - acc); end
    tests++; if (got_cyc[3] - got_cyc[0] !== 3) begin fails++; $display("FAIL intra_throughput got %0d want 3", got_cyc[3] - got_cyc[0]); end
  endtask

  task automatic test_inter_zero();
    int acc;
    clear_got();
    send_block(16'sd100, 16'sd100, -16'sd100, 16'sd0, 6'd28, 1'b0, acc);
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL inter_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== 16'sd0) begin fails++; $display("FAIL inter_z%0d got %0d want 0", i, got_z[i]); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL inter_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
    tests++; if (got_nz[3] !== 1'b0) begin fails++; $display("FAIL inter_nz got %b want 0", got_nz[3]); end
  endtask

  task automatic test_qp0_saturation();
    logic signed [15:0] ez[4] = '{16'sd1, -16'sd6553, 16'sd6553, 16'sd0};
    int acc;
    clear_got();
    send_block(16'sd5, -16'sd32768, 16'sd32767, -16'sd1, 6'd0, 1'b1, acc);
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL qp0_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== ez[i]) begin fails++; $display("FAIL qp0_z%0d got %0d want %0d", i, got_z[i], ez[i]); end
    end
    tests++; if (got_nz[3] !== 1'b1) begin fails++; $display("FAIL qp0_nz got %b want 1", got_nz[3]); end
  endtask

  // QP=60 clamps to 51; later QP/INTRA changes inside the block are ignored.
  task automatic test_qp_clamp();
    logic signed [15:0] ez[4] = '{16'sd18, 16'sd18, -16'sd18, 16'sd0};
    int a;
    clear_got();
    send(16'sd32767, 6'd60, 1'b1, a);
    send(16'sd32767, 6'd0, 1'b1, a);
    send(-16'sd32767, 6'd0, 1'b0, a);
    send(16'sd1000, 6'd0, 1'b0, a);
    dc.VALIDI = 1'b0;
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL clamp_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== ez[i]) begin fails++; $display("FAIL clamp_z%0d got %0d want %0d", i, got_z[i], ez[i]); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL clamp_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] ez[4] = '{16'sd15, -16'sd23, 16'sd4, 16'sd31};
    int acc;
    clear_got();
    dc.READYI = 1'b1;
    fork
      send_block(16'sd2000, -16'sd3000, 16'sd500, 16'sd4000, 6'd28, 1'b1, acc);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge CLK);
          if (dc.VALID) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL bp_first_valid got 0 want 1"); end
        @(posedge CLK);
        #1;
        dc.READYI = 1'b0;
        repeat (5) begin
          @(negedge CLK);
          tests++; if (dc.VALID !== 1'b1) begin fails++; $display("FAIL bp_stall_valid got %b want 1", dc.VALID); end
          tests++; if (dc.ZOUT !== -16'sd23) begin fails++; $display("FAIL bp_stall_zout got %0d want -23", dc.ZOUT); end
          tests++; if (dc.LAST !== 1'b0) begin fails++; $display("FAIL bp_stall_last got %b want 0", dc.LAST); end
          tests++; if (dc.READYO !== 1'b0) begin fails++; $display("FAIL bp_stall_readyo got %b want 0", dc.READYO); end
          @(posedge CLK);
          #1;
        end
        dc.READYI = 1'b1;
      end
    join
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL bp_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== ez[i]) begin fails++; $display("FAIL bp_z%0d got %0d want %0d", i, got_z[i], ez[i]); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL bp_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
    tests++; if (got_nz[3] !== 1'b1) begin fails++; $display("FAIL bp_nz got %b want 1", got_nz[3]); end
  endtask

  task automatic test_reset_midblock();
    logic signed [15:0] ez[4] = '{16'sd1, -16'sd6553, 16'sd6553, 16'sd0};
    int a;
    clear_got();
    send(16'sd1000, 6'd28, 1'b1, a);
    send(16'sd1000, 6'd28, 1'b1, a);
    dc.VALIDI = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    tests++; if (dc.VALID !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", dc.VALID); end
    tests++; if (dc.ZOUT !== 16'sd0) begin fails++; $display("FAIL midrst_zout got %0d want 0", dc.ZOUT); end
    tests++; if (dc.READYO !== 1'b0) begin fails++; $display("FAIL midrst_readyo got %b want 0", dc.READYO); end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    clear_got();
    send_block(16'sd5, -16'sd32768, 16'sd32767, -16'sd1, 6'd0, 1'b1, a);
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL midrst_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== ez[i]) begin fails++; $display("FAIL midrst_z%0d got %0d want %0d", i, got_z[i], ez[i]); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL midrst_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
  endtask

  // ENABLE drops for one cycle mid-block; the latched QP/INTRA must survive.
  task automatic test_enable_gap();
    logic signed [15:0] ez[4] = '{16'sd1, -16'sd1, 16'sd8, 16'sd0};
    int a;
    clear_got();
    send(16'sd100, 6'd28, 1'b1, a);
    send(-16'sd100, 6'd28, 1'b1, a);
    dc.ENABLE = 1'b0;
    dc.VALIDI = 1'b1;
    dc.YYIN   = 16'sd1000;
    dc.QP     = 6'd0;
    dc.INTRA  = 1'b0;
    @(negedge CLK);
    tests++; if (dc.READYO !== 1'b0) begin fails++; $display("FAIL gap_readyo got %b want 0", dc.READYO); end
    @(posedge CLK);
    #1;
    dc.ENABLE = 1'b1;
    send(16'sd1000, 6'd0, 1'b0, a);
    send(16'sd0, 6'd0, 1'b0, a);
    dc.VALIDI = 1'b0;
    wait_out(4);
    tests++; if (got_z.size() !== 4) begin fails++; $display("FAIL gap_count got %0d want 4", got_z.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (got_z[i] !== ez[i]) begin fails++; $display("FAIL gap_z%0d got %0d want %0d", i, got_z[i], ez[i]); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL gap_last%0d got %b want %b", i, got_last[i], (i == 3)); end
    end
    tests++; if (got_nz[3] !== 1'b1) begin fails++; $display("FAIL gap_nz got %b want 1", got_nz[3]); end
  endtask

  initial begin
    dc.ENABLE = 1'b0;
    dc.QP     = 6'd0;
    dc.INTRA  = 1'b0;
    dc.VALIDI = 1'b0;
    dc.YYIN   = 16'sd0;
    dc.READYI = 1'b1;
    test_reset();
    test_intra_basic();
    test_inter_zero();
    test_qp0_saturation();
    test_qp_clamp();
    test_backpressure();
    test_reset_midblock();
    test_enable_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
